// File: rtl/ctrl_loop_nest.sv
// rtl/ctrl_loop_nest.sv - programmable nested-loop counter chain for the DP control path
module ctrl_loop_nest #(
  parameter int NLEV = 3,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_load,
  input  logic [NLEV*W-1:0] max_val,
  input  logic              wrap_en,
  input  logic              clear,
  input  logic              inc,
  output logic [NLEV*W-1:0] cnt_val,
  output logic [NLEV-1:0]   term,
  output logic              last,
  output logic [NLEV-1:0]   wrap_pls,
  output logic              done_pls,
  output logic              done
);

  // Packed per-level storage; level i occupies [i*W +: W] when flattened.
  logic [NLEV-1:0][W-1:0] cnt_q;
  logic [NLEV-1:0][W-1:0] cnt_d;
  logic [NLEV-1:0][W-1:0] max_reg;
  logic                   mode_reg;
  logic                   acc;
  logic [NLEV:0]          carry;
  logic                   chain;

  assign cnt_val = cnt_q;
  assign last    = &term;

  // Terminal compare per level, taken from registered state only.
  always_comb begin
    term = '0;
    for (int i = 0; i < NLEV; i++) begin
      term[i] = (cnt_q[i] == max_reg[i]);
    end
  end

  // Accept the step and ripple the carry through terminal levels.
  // A scalar accumulator keeps the chain from looping back on one vector.
  always_comb begin
    acc   = inc & ~clear & ~cnt_load & ~(done & ~mode_reg);
    carry = '0;
    chain = acc;
    for (int i = 0; i < NLEV; i++) begin
      carry[i] = chain;
      chain    = chain & term[i];
    end
    carry[NLEV] = chain;
  end

  // Next counter values: increment, wrap to zero, or freeze at max on one-shot completion.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NLEV; i++) begin
      if (carry[i]) begin
        if (!term[i]) begin
          cnt_d[i] = cnt_q[i] + W'(1);
        end else if (mode_reg || !carry[NLEV]) begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // State register: clear beats cnt_load beats the counting step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      max_reg  <= '0;
      mode_reg <= 1'b0;
      wrap_pls <= '0;
      done_pls <= 1'b0;
      done     <= 1'b0;
    end else if (clear) begin
      cnt_q    <= '0;
      wrap_pls <= '0;
      done_pls <= 1'b0;
      done     <= 1'b0;
    end else if (cnt_load) begin
      max_reg  <= max_val;
      mode_reg <= wrap_en;
      cnt_q    <= '0;
      wrap_pls <= '0;
      done_pls <= 1'b0;
      done     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wrap_pls <= carry[NLEV:1];
      done_pls <= carry[NLEV];
      if (carry[NLEV]) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_loop_nest.sv
// tb/tb_ctrl_loop_nest.sv - directed self-checking bench for ctrl_loop_nest
module tb_ctrl_loop_nest;

  localparam int NLEV = 3;
  localparam int W    = 4;

  logic              clk;
  logic              rst;
  logic              cnt_load;
  logic [NLEV*W-1:0] max_val;
  logic              wrap_en;
  logic              clear;
  logic              inc;
  logic [NLEV*W-1:0] cnt_val;
  logic [NLEV-1:0]   term;
  logic              last;
  logic [NLEV-1:0]   wrap_pls;
  logic              done_pls;
  logic              done;

  int checks;
  int failures;

  ctrl_loop_nest #(.NLEV(NLEV), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_load (cnt_load),
    .max_val  (max_val),
    .wrap_en  (wrap_en),
    .clear    (clear),
    .inc      (inc),
    .cnt_val  (cnt_val),
    .term     (term),
    .last     (last),
    .wrap_pls (wrap_pls),
    .done_pls (done_pls),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counters for config {L2=2,L1=1,L0=3} after k incs (period 24).
  function automatic logic [11:0] exp_cnt(input int k, input bit oneshot);
    int m;
    if (oneshot && k >= 24) return {4'd2, 4'd1, 4'd3};
    m = k % 24;
    return {4'(m / 8), 4'((m / 4) % 2), 4'(m % 4)};
  endfunction

  task automatic load_cfg(input logic [11:0] mv, input logic we);
    cnt_load = 1'b1;
    max_val  = mv;
    wrap_en  = we;
    @(negedge clk);
    cnt_load = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (cnt_val !== 12'h000) begin failures++; $display("FAIL reset_cnt got=%h exp=%h", cnt_val, 12'h000); end
    checks++;
    if (term !== 3'b111 || last !== 1'b1) begin failures++; $display("FAIL reset_term got=%b/%b exp=111/1", term, last); end
    checks++;
    if (done !== 1'b0 || done_pls !== 1'b0 || wrap_pls !== 3'b000) begin
      failures++; $display("FAIL reset_flags got done=%b dp=%b wp=%b exp=0/0/000", done, done_pls, wrap_pls);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_incs(input bit oneshot, input string tag);
    logic [2:0] ew;
    for (int k = 1; k <= 24; k++) begin
      inc = 1'b1;
      @(negedge clk);
      ew = {(k % 24 == 0), (k % 8 == 0), (k % 4 == 0)};
      checks++;
      if (cnt_val !== exp_cnt(k, oneshot)) begin
        failures++; $display("FAIL %s_cnt k=%0d got=%h exp=%h", tag, k, cnt_val, exp_cnt(k, oneshot));
      end
      checks++;
      if (wrap_pls !== ew) begin failures++; $display("FAIL %s_wrap k=%0d got=%b exp=%b", tag, k, wrap_pls, ew); end
      checks++;
      if (done_pls !== (k == 24)) begin failures++; $display("FAIL %s_done_pls k=%0d got=%b exp=%b", tag, k, done_pls, (k == 24)); end
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL %s_done got=%b exp=1", tag, done); end
    // 25th inc
    @(negedge clk);
    inc = 1'b0;
    checks++;
    if (cnt_val !== exp_cnt(25, oneshot)) begin
      failures++; $display("FAIL %s_cnt25 got=%h exp=%h", tag, cnt_val, exp_cnt(25, oneshot));
    end
    checks++;
    if (done_pls !== 1'b0 || wrap_pls !== (oneshot ? 3'b000 : 3'b000)) begin
      failures++; $display("FAIL %s_pls25 got dp=%b wp=%b exp=0/000", tag, done_pls, wrap_pls);
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL %s_done25 got=%b exp=1", tag, done); end
  endtask

  task automatic test_oneshot();
    load_cfg({4'd2, 4'd1, 4'd3}, 1'b0);
    checks++;
    if (cnt_val !== 12'h000 || term !== 3'b000 || last !== 1'b0) begin
      failures++; $display("FAIL load_state got cnt=%h term=%b last=%b exp=000/000/0", cnt_val, term, last);
    end
    run_incs(1'b1, "oneshot");
    checks++;
    if (last !== 1'b1) begin failures++; $display("FAIL oneshot_last got=%b exp=1", last); end
  endtask

  task automatic test_freerun();
    load_cfg({4'd2, 4'd1, 4'd3}, 1'b1);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL freerun_load_done got=%b exp=0", done); end
    run_incs(1'b0, "freerun");
  endtask

  task automatic test_clear();
    inc = 1'b1;
    @(negedge clk);
    inc = 1'b0;
    checks++;
    if (cnt_val !== 12'h002) begin failures++; $display("FAIL clear_pre got=%h exp=%h", cnt_val, 12'h002); end
    clear = 1'b1;
    inc   = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    inc   = 1'b0;
    checks++;
    if (cnt_val !== 12'h000) begin failures++; $display("FAIL clear_cnt got=%h exp=%h", cnt_val, 12'h000); end
    checks++;
    if (done !== 1'b0 || done_pls !== 1'b0 || wrap_pls !== 3'b000) begin
      failures++; $display("FAIL clear_flags got done=%b dp=%b wp=%b exp=0/0/000", done, done_pls, wrap_pls);
    end
    checks++;
    if (term !== 3'b000) begin failures++; $display("FAIL clear_cfg_kept term got=%b exp=000", term); end
  endtask

  task automatic test_zero_level();
    load_cfg({4'd2, 4'd0, 4'd3}, 1'b0);
    checks++;
    if (term !== 3'b010) begin failures++; $display("FAIL zl_term got=%b exp=010", term); end
    for (int k = 1; k <= 3; k++) begin
      inc = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (cnt_val !== 12'h003 || wrap_pls !== 3'b000) begin
      failures++; $display("FAIL zl_pre got cnt=%h wp=%b exp=003/000", cnt_val, wrap_pls);
    end
    @(negedge clk);
    inc = 1'b0;
    checks++;
    if (cnt_val !== 12'h100) begin failures++; $display("FAIL zl_cnt got=%h exp=%h", cnt_val, 12'h100); end
    checks++;
    if (wrap_pls !== 3'b011 || done_pls !== 1'b0) begin
      failures++; $display("FAIL zl_wrap got wp=%b dp=%b exp=011/0", wrap_pls, done_pls);
    end
  endtask

  task automatic test_load_mid();
    inc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    inc = 1'b0;
    checks++;
    if (cnt_val !== 12'h102) begin failures++; $display("FAIL lm_pre got=%h exp=%h", cnt_val, 12'h102); end
    cnt_load = 1'b1;
    inc      = 1'b1;
    max_val  = {4'd1, 4'd1, 4'd1};
    wrap_en  = 1'b1;
    @(negedge clk);
    cnt_load = 1'b0;
    inc      = 1'b0;
    checks++;
    if (cnt_val !== 12'h000 || wrap_pls !== 3'b000 || done_pls !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL lm_state got cnt=%h wp=%b dp=%b d=%b exp=000/000/0/0", cnt_val, wrap_pls, done_pls, done);
    end
    inc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    inc = 1'b0;
    checks++;
    if (cnt_val !== 12'h010 || wrap_pls !== 3'b001) begin
      failures++; $display("FAIL lm_newmax got cnt=%h wp=%b exp=010/001", cnt_val, wrap_pls);
    end
  endtask

  task automatic test_async_reset();
    load_cfg({4'd2, 4'd1, 4'd3}, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      inc = 1'b1;
      @(negedge clk);
    end
    inc = 1'b0;
    checks++;
    if (cnt_val !== 12'h102) begin failures++; $display("FAIL ar_pre got=%h exp=%h", cnt_val, 12'h102); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cnt_val !== 12'h000 || done !== 1'b0) begin
      failures++; $display("FAIL ar_immediate got cnt=%h done=%b exp=000/0", cnt_val, done);
    end
    checks++;
    if (term !== 3'b111 || last !== 1'b1) begin failures++; $display("FAIL ar_term got=%b/%b exp=111/1", term, last); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cnt_val !== 12'h000 || done !== 1'b0 || done_pls !== 1'b0 || wrap_pls !== 3'b000) begin
      failures++; $display("FAIL ar_idle got cnt=%h d=%b dp=%b wp=%b exp=000/0/0/000", cnt_val, done, done_pls, wrap_pls);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    cnt_load = 1'b0;
    max_val  = '0;
    wrap_en  = 1'b0;
    clear    = 1'b0;
    inc      = 1'b0;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_freerun();
    test_clear();
    test_zero_level();
    test_load_mid();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
